cic_frame_writer: RTL and testbench
===================================

# cic_frame_writer

Downstream consumer of the time-multiplexed CIC decimator in the mic array path. Takes one CIC output word per channel per decimated sample, applies a programmable arithmetic right-shift gain with saturation to PCM width, and writes it into an external dual-port frame memory organised as two ping-pong banks. It raises a frame interrupt to the bus side when a bank fills, and flags overrun if that interrupt is not acknowledged before the next bank fills.

## Interface
- CIC_WIDTH, 22: width of signed CIC output word.
- CHANNELS, 8: microphone channels (power of 2).
- DATA_WIDTH, 16: signed PCM width written to memory.
- FRAME_SAMPLES, 256: samples per channel per bank (power of 2).
- SHIFT_WIDTH, 5: width of gain_shift.
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  block enable; low holds the block idle and clears state.
- cic_data  in  CIC_WIDTH  signed CIC output.
- cic_channel  in  $clog2(CHANNELS)  channel of cic_data.
- cic_valid  in  1  one-cycle strobe: cic_data/cic_channel valid (CIC write_memory).
- gain_shift  in  SHIFT_WIDTH  arithmetic right-shift amount; sampled with cic_valid.
- irq_ack  in  1  one-cycle acknowledge of frame_irq.
- mem_addr  out  1+$clog2(FRAME_SAMPLES)+$clog2(CHANNELS)  {bank, sample_idx, channel}.
- mem_data  out  DATA_WIDTH  signed PCM word.
- mem_we  out  1  one-cycle write strobe.
- frame_irq  out  1  level; a bank is complete and unacknowledged.
- frame_bank  out  1  bank index of the most recently completed bank.
- overrun  out  1  sticky; a bank completed while frame_irq was still high.

## Operation
- Reset values: mem_addr 0, mem_data 0, mem_we 0, frame_irq 0, frame_bank 0, overrun 0; internal bank 0, sample_idx 0, armed 0.
- States: IDLE (enable=0), ARMING (enable=1, waiting for first cic_valid with cic_channel==0), RUN.
- IDLE: no writes; bank, sample_idx, armed, frame_irq, overrun, frame_bank cleared synchronously; in-flight pipeline words are discarded (mem_we forced 0).
- ARMING -> RUN on cic_valid with cic_channel==0; that word is written. cic_valid with cic_channel!=0 in ARMING is dropped.
- enable falling in any state -> IDLE next cycle.
- Stage 1: shifted = cic_data >>> gain_shift (sign-extending). gain_shift >= CIC_WIDTH yields 0 or -1.
- Stage 2: saturate shifted to DATA_WIDTH: > 2^(DATA_WIDTH-1)-1 -> max; < -2^(DATA_WIDTH-1) -> min; else truncate to low DATA_WIDTH bits.
- Address: channel field = cic_channel of that word; bank and sample_idx are current counters at acceptance.
- After accepting a word with cic_channel==CHANNELS-1: sample_idx++; at wrap from FRAME_SAMPLES-1 to 0, bank toggles and a frame-complete event is generated for the old bank.
- Frame-complete event: frame_bank <= completed bank; frame_irq <= 1; if frame_irq already 1 and no irq_ack that cycle, overrun <= 1.
- irq_ack clears frame_irq; simultaneous irq_ack and frame-complete: frame_irq stays 1, overrun not set, frame_bank updated.
- overrun cleared only by reset or enable=0.
- Out-of-order channels are not checked; channel field follows cic_channel.

## Timing
- cic_valid at cycle T -> mem_we, mem_addr, mem_data valid at T+2 (one cycle wide).
- Back-to-back cic_valid every cycle supported; throughput one word/cycle.
- Frame-complete event: frame_irq rises at T+3 for last word accepted at T (one cycle after its mem_we).
- frame_irq falls the cycle after irq_ack.
- mem_data/mem_addr hold last values when mem_we=0.
- Asynchronous resetn assertion mid-frame: all outputs to reset values immediately; after release, block starts in ARMING if enable=1.

## Test plan
(CIC_WIDTH=22, CHANNELS=8, FRAME_SAMPLES=4, address width 6.)
- Reset: assert resetn=0 during activity -> all outputs 0 asynchronously; release with enable=1, valid on channel 0 -> first mem_we at addr 0 two cycles later.
- Gain/saturation: shift 0, data 1048575 -> mem_data 16'h7FFF; data -1048576 -> 16'h8000; shift 5, data 1000 -> 16'h001F; data -1000 -> 16'hFFE0; shift 31, data -5 -> 16'hFFFF.
- Addressing: 16 valids, channels 0..7 twice, one per cycle -> mem_we on 16 consecutive cycles, addr 0..15, latency 2.
- Frame/ping-pong: 32 valids -> frame_irq=1 at T+3 after 32nd, frame_bank=0; 33rd word addr 32; irq_ack -> frame_irq=0 next cycle; 32 more -> frame_bank=1, next addr 0.
- Overrun and ack collision: skip ack across two frames -> overrun=1 and stays 1; separately, irq_ack coincident with frame-complete -> frame_irq=1, overrun=0.
- Arming/enable: enable rises, valids on channels 3..7 -> no mem_we; channel 0 -> write at addr 0; drop enable mid-frame -> pipeline word not written, counters/flags 0.

Source files
------------

// File: rtl/cic_frame_writer.sv
// cic_frame_writer: gain/saturate time-multiplexed CIC words and write them into ping-pong frame banks.
module cic_frame_writer #(
    parameter int CIC_WIDTH     = 22,
    parameter int CHANNELS      = 8,
    parameter int DATA_WIDTH    = 16,
    parameter int FRAME_SAMPLES = 256,
    parameter int SHIFT_WIDTH   = 5
) (
    input  logic                                                   clk,
    input  logic                                                   resetn,
    input  logic                                                   enable,
    input  logic [CIC_WIDTH-1:0]                                   cic_data,
    input  logic [$clog2(CHANNELS)-1:0]                            cic_channel,
    input  logic                                                   cic_valid,
    input  logic [SHIFT_WIDTH-1:0]                                 gain_shift,
    input  logic                                                   irq_ack,
    output logic [$clog2(FRAME_SAMPLES)+$clog2(CHANNELS):0]        mem_addr,
    output logic [DATA_WIDTH-1:0]                                  mem_data,
    output logic                                                   mem_we,
    output logic                                                   frame_irq,
    output logic                                                   frame_bank,
    output logic                                                   overrun
);
    localparam int CHW = $clog2(CHANNELS);
    localparam int SW  = $clog2(FRAME_SAMPLES);
    localparam int AW  = 1 + SW + CHW;
    localparam logic [DATA_WIDTH-1:0] DMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] DMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ARMING, RUN} state_t;
    state_t state, state_n;

    logic                        accept, last_ch, wrap, ovf;
    logic                        bank, v1, last1, fc2;
    logic [SW-1:0]               sample_idx;
    logic signed [CIC_WIDTH-1:0] sh1;
    logic [AW-1:0]               addr1;
    logic [DATA_WIDTH-1:0]       sat;

    // IDLE with enable high behaves like ARMING so a channel-0 word right after reset release is kept
    always_comb begin
        accept  = enable && cic_valid && (state == RUN || cic_channel == '0);
        last_ch = cic_channel == CHW'(CHANNELS - 1);
        wrap    = accept && last_ch && sample_idx == SW'(FRAME_SAMPLES - 1);
        state_n = !enable ? IDLE : (state == RUN || accept) ? RUN : ARMING;
        ovf     = sh1[CIC_WIDTH-1:DATA_WIDTH-1] != {(CIC_WIDTH-DATA_WIDTH+1){sh1[CIC_WIDTH-1]}};
        sat     = ovf ? (sh1[CIC_WIDTH-1] ? DMIN : DMAX) : sh1[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= IDLE;
        else         state <= state_n;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1         <= 1'b0;
            last1      <= 1'b0;
            sh1        <= '0;
            addr1      <= '0;
            fc2        <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            bank       <= 1'b0;
            sample_idx <= '0;
            frame_irq  <= 1'b0;
            frame_bank <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            v1     <= accept;
            last1  <= wrap;
            mem_we <= enable && v1;
            fc2    <= enable && v1 && last1;
            if (accept) begin
                sh1   <= $signed(cic_data) >>> gain_shift;
                addr1 <= {bank, sample_idx, cic_channel};
            end
            if (enable && v1) begin
                mem_data <= sat;
                mem_addr <= addr1;
            end
            if (!enable) begin
                bank       <= 1'b0;
                sample_idx <= '0;
                frame_irq  <= 1'b0;
                frame_bank <= 1'b0;
                overrun    <= 1'b0;
            end else begin
                if (accept && last_ch) begin
                    sample_idx <= sample_idx + 1'b1;
                    bank       <= bank ^ wrap;
                end
                // mem_addr still holds the last word of the completed bank when fc2 is seen
                frame_irq <= fc2 || (frame_irq && !irq_ack);
                if (fc2 && frame_irq && !irq_ack) overrun <= 1'b1;
                if (fc2) frame_bank <= mem_addr[AW-1];
            end
        end
    end
endmodule

// File: tb/tb_cic_frame_writer.sv
// tb_cic_frame_writer: scoreboard bench for cic_frame_writer (8 channels, 4 samples per bank).
module tb_cic_frame_writer;
    logic        clk = 0, resetn = 0, enable = 0, cic_valid = 0, irq_ack = 0;
    logic [21:0] cic_data = '0;
    logic [2:0]  cic_channel = '0;
    logic [4:0]  gain_shift = '0;
    logic [5:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_we, frame_irq, frame_bank, overrun;

    cic_frame_writer #(
        .CIC_WIDTH(22), .CHANNELS(8), .DATA_WIDTH(16), .FRAME_SAMPLES(4), .SHIFT_WIDTH(5)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .cic_data(cic_data),
        .cic_channel(cic_channel), .cic_valid(cic_valid), .gain_shift(gain_shift),
        .irq_ack(irq_ack), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .frame_irq(frame_irq), .frame_bank(frame_bank), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; logic [5:0] addr; logic [15:0] data;} wr_t;
    typedef struct {int cyc; int id; logic [15:0] exp;} fl_t;
    wr_t sq[$];
    fl_t fq[$];
    int checks = 0, errors = 0;
    int m_bank = 0, m_idx = 0, last_c = 0;
    string nm[7] = '{"mem_we", "mem_addr", "mem_data", "frame_irq", "frame_bank", "overrun", "pending_writes"};

    always @(negedge clk) begin
        if (resetn && mem_we) begin
            if (sq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write cyc=%0d addr=%0d data=%h", cyc, mem_addr, mem_data);
            end else begin
                wr_t e;
                e = sq.pop_front();
                checks += 3;
                if (cyc != e.cyc) begin errors++; $display("FAIL write_cycle got=%0d exp=%0d", cyc, e.cyc); end
                if (mem_addr !== e.addr) begin errors++; $display("FAIL write_addr got=%0d exp=%0d", mem_addr, e.addr); end
                if (mem_data !== e.data) begin errors++; $display("FAIL write_data addr=%0d got=%h exp=%h", e.addr, mem_data, e.data); end
            end
        end
        while (fq.size() > 0 && fq[0].cyc <= cyc) begin
            fl_t f;
            logic [15:0] act;
            f = fq.pop_front();
            act = f.id == 0 ? 16'(mem_we) : f.id == 1 ? 16'(mem_addr) : f.id == 2 ? mem_data :
                  f.id == 3 ? 16'(frame_irq) : f.id == 4 ? 16'(frame_bank) : f.id == 5 ? 16'(overrun) : 16'(sq.size());
            checks++;
            if (act !== f.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm[f.id], cyc, act, f.exp);
            end
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic expect_v(input int id, input logic [15:0] v); fq.push_back('{cyc, id, v}); endtask
    task automatic wait_to(input int c); while (cyc < c) tick(); endtask
    task automatic model_clear(); m_bank = 0; m_idx = 0; endtask

    task automatic send(input int ch, input int data, input int sh, input logic [15:0] ed, input bit wr);
        cic_valid = 1; cic_channel = 3'(ch); cic_data = 22'(data); gain_shift = 5'(sh); last_c = cyc;
        if (wr) begin
            sq.push_back('{cyc + 2, 6'((m_bank << 5) | (m_idx << 3) | ch), ed});
            if (ch == 7) begin
                m_idx = (m_idx + 1) % 4;
                if (m_idx == 0) m_bank ^= 1;
            end
        end
        tick();
        cic_valid = 0;
    endtask

    task automatic words(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            int d;
            d = (i * 37) % 2000 - 1000;
            send((start + i) % 8, d, 0, 16'(d), 1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        #12;
        for (int i = 0; i < 6; i++) expect_v(i, 16'h0);
        tick();
        enable = 1; resetn = 1;
        send(0, 1048575, 0, 16'h7FFF, 1);
        send(1, -1048576, 0, 16'h8000, 1);
        send(2, 1000, 5, 16'h001F, 1);
        send(3, -1000, 5, 16'hFFE0, 1);
        send(4, -5, 31, 16'hFFFF, 1);
        send(5, -32768, 0, 16'h8000, 1);
        send(6, 32767, 0, 16'h7FFF, 1);
        send(7, 32768, 0, 16'h7FFF, 1);
        tick(); tick();
        send(0, 123, 0, 16'h0, 0);
        resetn = 0;
        #1;
        for (int i = 0; i < 6; i++) expect_v(i, 16'h0);
        tick();
        model_clear();
        resetn = 1;
        words(0, 32);
        c = last_c;
        wait_to(c + 2); expect_v(3, 0);
        wait_to(c + 3); expect_v(3, 1); expect_v(4, 0); expect_v(5, 0);
        send(0, 500, 0, 16'd500, 1);
        irq_ack = 1; tick(); irq_ack = 0;
        expect_v(3, 0);
        words(1, 31);
        c = last_c;
        wait_to(c + 3); expect_v(3, 1); expect_v(4, 1); expect_v(5, 0);
        words(0, 32);
        c = last_c;
        wait_to(c + 3); expect_v(5, 1); expect_v(4, 0); expect_v(3, 1);
        repeat (3) tick();
        irq_ack = 1; tick(); irq_ack = 0;
        expect_v(3, 0); expect_v(5, 1);
        enable = 0; tick(); model_clear();
        expect_v(5, 0); expect_v(3, 0); expect_v(4, 0);
        enable = 1;
        words(0, 32);
        c = last_c;
        wait_to(c + 3); expect_v(3, 1);
        words(0, 32);
        c = last_c;
        wait_to(c + 2);
        irq_ack = 1; tick(); irq_ack = 0;
        expect_v(3, 1); expect_v(5, 0); expect_v(4, 1);
        enable = 0; tick(); model_clear();
        enable = 1;
        for (int ch = 3; ch < 8; ch++) send(ch, ch, 0, 16'h0, 0);
        send(0, 11, 0, 16'd11, 1);
        for (int ch = 1; ch < 8; ch++) send(ch, ch, 0, 16'(ch), 1);
        send(0, 22, 0, 16'd22, 1);
        send(1, 33, 0, 16'h0, 0);
        enable = 0;
        tick();
        expect_v(0, 0); expect_v(3, 0); expect_v(5, 0); expect_v(4, 0);
        tick();
        model_clear();
        enable = 1;
        send(0, 44, 0, 16'd44, 1);
        repeat (4) tick();
        expect_v(6, 0);
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
